fetch_byte_queue: RTL and testbench
===================================

Name: fetch_byte_queue

Overview:
- Front end of the Y86-64 fetch stage, directly upstream of the split/align logic.
- Owns the PC and issues aligned 8-byte reads to instruction memory.
- Queues the returned bytes and presents one complete instruction per handshake as Byte0..Byte9 plus PC, valP and predecode flags.
- Split/align consume the byte vector; decode consumes the handshake.

Parameters:
- DEPTH, 16, byte-queue capacity in bytes; power of two, >= 16.
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  64  read address; always 8-aligned; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse, read data valid.
- mem_rdata  in  64  8 bytes, little-endian: byte k = bits [8k+7:8k].
- instr_valid  out  1  complete instruction at queue head.
- instr_ready  in  1  consumer accepts head instruction.
- instr_bytes  out  80  Byte0 = bits [7:0] ... Byte9 = bits [79:72]; bytes beyond length are don't-care.
- instr_pc  out  64  address of Byte0.
- instr_valp  out  64  instr_pc + instr_len.
- instr_len  out  4  1, 2, 9 or 10.
- need_regids  out  1  instruction has an rA:rB byte.
- need_valc  out  1  instruction has an 8-byte constant.
- instr_err  out  1  icode invalid; length forced to 1.
- pc_load  in  1  redirect request.
- pc_new  in  64  redirect target.

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty, count=0; head PC = RESET_PC; fetch_addr = RESET_PC & ~7; discard offset = RESET_PC[2:0].
  - No outstanding request; halted=0.
  - All outputs 0 except mem_addr = RESET_PC & ~7.
- Length decode, from icode = Byte0[7:4]:
  - 0 halt, 1 nop, 9 ret -> 1.
  - 2 cmovXX, 6 OPq, A pushq, B popq -> 2 (need_regids).
  - 3 irmovq, 4 rmmovq, 5 mrmovq -> 10 (need_regids, need_valc).
  - 7 jXX, 8 call -> 9 (need_valc only).
  - C..F -> 1 with instr_err=1.
- Output handshake:
  - instr_valid = count >= instr_len and count >= 1 (count >= 1 required to decode length) and no pc_load this cycle.
  - Outputs are combinational from queue head.
  - Transfer when instr_valid and instr_ready: pop instr_len bytes; head PC += instr_len.
  - instr_valid is not held by instr_ready; outputs stay stable while valid and not accepted.
- Fetch:
  - Issue mem_req when: no request outstanding, halted=0, and count + 8 <= DEPTH (count sampled before same-cycle pop).
  - mem_req is registered: it asserts the cycle after the condition holds.
  - On mem_ack, push bytes offset..7 of mem_rdata, clear offset to 0, fetch_addr += 8.
  - Only one request outstanding at a time.
- Simultaneous push and pop in the same cycle is legal: count_next = count + pushed - popped.
- Halt:
  - On acceptance of icode 0 or an instr_err instruction, set halted=1.
  - No new requests while halted; a pending request completes normally.
  - Queued bytes remain presented.
- Redirect (pc_load=1):
  - Highest priority; overrides a same-cycle pop and push.
  - Flush queue; head PC = pc_new; fetch_addr = pc_new & ~7; offset = pc_new[2:0]; halted=0.
  - If a request is outstanding, set drop flag: that request stays asserted until its mem_ack, the data is discarded, and the new request issues the cycle after.
  - instr_valid=0 in the redirect cycle.
- Width rules:
  - PC and fetch_addr are 64-bit and wrap modulo 2^64.
  - Queue pointers wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Reset mid-operation: immediate return to reset state; any in-flight mem_ack after reset is ignored until the first new request is issued.

Test Plan:
- Reset with RESET_PC=0; memory at 0 = 30 F4 FF FF FF FF FF FF FF FF, then 60 12 -> after 2 acks: instr_valid, instr_len=10, need_regids=1, need_valc=1, instr_valp=10; accept -> next head 60 12, len 2, instr_pc=10, valp=12.
- instr_ready held 0 with 16 bytes queued -> mem_req stays 0; outputs stable; accept -> mem_req asserts the next cycle.
- pc_load with pc_new=0x13 while a request is outstanding -> ack data dropped; next mem_addr=0x10; bytes 0x10..0x12 discarded; instr_pc=0x13.
- Stream 10 00 ... (nop, halt) -> two len-1 instructions; after halt is accepted, no further mem_req until pc_load.
- Head byte 0xC0 -> instr_err=1, len=1, valp=pc+1; halted after accept.
- Assert rst_n=0 mid-request, then ack on the next cycle -> ack ignored; count=0; first new request at RESET_PC.

Source files
------------

// File: rtl/fetch_byte_queue.sv
// Y86-64 fetch front end: owns the PC, prefetches aligned 8-byte words and
// presents one length-decoded instruction per valid/ready handshake.
module fetch_byte_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [79:0] instr_bytes,
  output logic [63:0] instr_pc,
  output logic [63:0] instr_valp,
  output logic [3:0]  instr_len,
  output logic        need_regids,
  output logic        need_valc,
  output logic        instr_err,
  input  logic        pc_load,
  input  logic [63:0] pc_new
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [3:0] len;
    logic       regids;
    logic       valc;
    logic       err;
  } dec_t;

  logic [7:0]    q_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [63:0]   head_pc_q, fetch_addr_q, req_addr_q;
  logic [2:0]    offset_q;
  logic          req_q, drop_q, halted_q;

  dec_t          dec;
  logic [3:0]    icode;
  logic          has_head;
  logic          pop, push, issue, halt_now;
  logic [3:0]    push_cnt;
  logic [CW-1:0] pushed, popped;

  assign has_head = (count_q != '0);

  // Window of the next ten queued bytes; zero while the queue is empty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    instr_bytes = '0;
    for (int i = 0; i < 10; i++) begin
      if (has_head) instr_bytes[8*i +: 8] = q_mem[rd_ptr_q + PW'(i)];
    end
  end

  assign icode = instr_bytes[7:4];

  always_comb begin
    dec = '{len: 4'd1, regids: 1'b0, valc: 1'b0, err: 1'b0};
    unique case (icode)
      4'h0, 4'h1, 4'h9:       dec.len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: dec = '{len: 4'd2,  regids: 1'b1, valc: 1'b0, err: 1'b0};
      4'h3, 4'h4, 4'h5:       dec = '{len: 4'd10, regids: 1'b1, valc: 1'b1, err: 1'b0};
      4'h7, 4'h8:             dec = '{len: 4'd9,  regids: 1'b0, valc: 1'b1, err: 1'b0};
      default:                dec.err = 1'b1;
    endcase
  end

  assign instr_len   = has_head ? dec.len    : 4'd0;
  assign need_regids = has_head && dec.regids;
  assign need_valc   = has_head && dec.valc;
  assign instr_err   = has_head && dec.err;
  assign instr_pc    = head_pc_q;
  assign instr_valp  = head_pc_q + 64'(instr_len);
  assign instr_valid = has_head && (count_q >= CW'(dec.len)) && !pc_load;

  assign mem_req  = req_q;
  assign mem_addr = req_addr_q;

  assign pop      = instr_valid && instr_ready;
  assign halt_now = pop && (icode == 4'h0 || dec.err);
  // Acks with no request outstanding (e.g. straddling a reset) are ignored.
  assign push     = mem_ack && req_q && !drop_q && !pc_load;
  assign push_cnt = 4'd8 - {1'b0, offset_q};
  assign pushed   = push ? CW'(push_cnt) : '0;
  assign popped   = pop ? CW'(instr_len) : '0;
  assign issue    = !req_q && !halted_q && !pc_load && (count_q <= CW'(DEPTH - 8));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= {RESET_PC[63:3], 3'b000};
      req_addr_q   <= {RESET_PC[63:3], 3'b000};
      offset_q     <= RESET_PC[2:0];
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else if (pc_load) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_pc_q    <= pc_new;
      fetch_addr_q <= {pc_new[63:3], 3'b000};
      offset_q     <= pc_new[2:0];
      halted_q     <= 1'b0;
      // An in-flight read must still complete; its data is thrown away.
      req_q        <= req_q && !mem_ack;
      drop_q       <= req_q && !mem_ack;
    end else begin
      count_q <= count_q + pushed - popped;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(instr_len);
        head_pc_q <= head_pc_q + 64'(instr_len);
      end
      if (halt_now) halted_q <= 1'b1;
      if (mem_ack && req_q) begin
        req_q  <= 1'b0;
        drop_q <= 1'b0;
        if (!drop_q) begin
          wr_ptr_q     <= wr_ptr_q + PW'(push_cnt);
          fetch_addr_q <= fetch_addr_q + 64'd8;
          offset_q     <= 3'd0;
        end
      end else if (issue) begin
        req_q      <= 1'b1;
        req_addr_q <= fetch_addr_q;
      end
    end
  end

  // NOTE: the byte store has no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 8; k++) begin
        if (k >= int'(offset_q))
          q_mem[wr_ptr_q + PW'(k) - PW'(offset_q)] <= mem_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: decode table, directed corner sequences, and a
// randomized run against an instruction-level model of a generated program.
module tb_fetch_byte_queue;

  logic        clk, rst_n;
  logic        mem_req, mem_ack;
  logic [63:0] mem_addr, mem_rdata;
  logic        instr_valid, instr_ready;
  logic [79:0] instr_bytes;
  logic [63:0] instr_pc, instr_valp, pc_new;
  logic [3:0]  instr_len;
  logic        need_regids, need_valc, instr_err, pc_load;

  fetch_byte_queue #(.DEPTH(16), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_bytes(instr_bytes),
    .instr_pc(instr_pc), .instr_valp(instr_valp), .instr_len(instr_len),
    .need_regids(need_regids), .need_valc(need_valc), .instr_err(instr_err),
    .pc_load(pc_load), .pc_new(pc_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction memory image and responder
  logic [7:0]  img [1024];
  int          req_log [$];
  bit          auto_mem = 1'b1;
  int          fixed_lat = -1;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [63:0] paddr;

  always begin
    @(negedge clk);
    if (!auto_mem || !rst_n) begin
      pend = 1'b0;
      if (auto_mem) mem_ack = 1'b0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!pend) begin
          pend  = 1'b1;
          paddr = mem_addr;
          lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          req_log.push_back(int'(mem_addr[31:0]));
          check("req_align", 80'(mem_addr[2:0]), 80'(0));
        end else begin
          check("req_stable", 80'(mem_addr), 80'(paddr));
        end
        if (lat == 0) begin
          for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = img[(int'(paddr[9:0]) + k) & 1023];
          mem_ack = 1'b1;
          pend    = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check(name, 80'(instr_valid), 80'(1));
  endtask

  task automatic wait_req(input string name, input logic val, input int budget);
    int n;
    n = 0;
    while (mem_req !== val && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check(name, 80'(mem_req), 80'(val));
  endtask

  // One cycle with instr_ready high; returns at the following negedge + 1.
  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
  endtask

  task automatic redirect(input logic [63:0] target);
    @(negedge clk);
    pc_load = 1'b1;
    pc_new  = target;
    #1;
    check("redirect_valid_low", 80'(instr_valid), 80'(0));
    @(negedge clk);
    pc_load = 1'b0;
    #1;
  endtask

  task automatic idle_no_req(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      if (mem_req) seen++;
    end
    check(name, 80'(seen), 80'(0));
  endtask

  typedef struct {
    logic [7:0] byte0;
    logic [3:0] len;
    logic       rg;
    logic       vc;
    logic       err;
  } vec_t;

  vec_t vecs [16];

  // Model of the random program: one record per instruction start address.
  int rec_len [int];
  bit rec_rg  [int];
  bit rec_vc  [int];
  int starts  [$];

  int          p, ic, ln, lsz, accepted, idle, cyc, key;
  bit          rg, vc;
  logic [3:0]  icn;
  logic [63:0] exp_pc;
  logic [79:0] exp_b, mask;

  initial begin
    vecs[0]  = '{8'h05, 4'd1,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h10, 4'd1,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h25, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h30, 4'd10, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'h40, 4'd10, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'h50, 4'd10, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h61, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h73, 4'd9,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h80, 4'd9,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h90, 4'd1,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hA0, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'hB0, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'hC0, 4'd1,  1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'hD7, 4'd1,  1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'hE0, 4'd1,  1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'hFF, 4'd1,  1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 1024; i++) img[i] = 8'h10;
    img[0] = 8'h30; img[1] = 8'hF4;
    for (int i = 2; i < 10; i++) img[i] = 8'hFF;
    img[10] = 8'h60; img[11] = 8'h12;
    img[16] = 8'hAA; img[17] = 8'hAA; img[18] = 8'hAA;
    img[19] = 8'h10; img[20] = 8'h00;
    img[64] = 8'hC0;

    rst_n = 1'b0; instr_ready = 1'b0; pc_load = 1'b0; pc_new = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 80'({mem_req, instr_valid, instr_len, need_regids, need_valc, instr_err}), 80'(0));
    check("reset_mem_addr", 80'(mem_addr), 80'(0));
    check("reset_pc", 80'(instr_pc), 80'(0));
    check("reset_valp", 80'(instr_valp), 80'(0));
    check("reset_bytes", instr_bytes, 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // irmovq after two acks, then the following OPq
    wait_valid("irmovq_valid", 60);
    check("irmovq_flags", 80'({instr_len, need_regids, need_valc, instr_err}), 80'({4'd10, 1'b1, 1'b1, 1'b0}));
    check("irmovq_pc", 80'(instr_pc), 80'(0));
    check("irmovq_valp", 80'(instr_valp), 80'(10));
    check("irmovq_bytes", instr_bytes, {{8{8'hFF}}, 8'hF4, 8'h30});
    repeat (10) begin @(negedge clk); #1; end
    check("full_no_req", 80'(mem_req), 80'(0));
    check("stall_stable", {instr_valid, instr_pc[15:0], instr_bytes[15:0]}, {1'b1, 16'h0, 16'hF430});
    fixed_lat = 8;
    accept();
    check("opq_pc", 80'(instr_pc), 80'(10));
    check("opq_flags", 80'({instr_len, need_regids, need_valc, instr_err}), 80'({4'd2, 1'b1, 1'b0, 1'b0}));
    check("opq_valp", 80'(instr_valp), 80'(12));
    check("opq_bytes", 80'(instr_bytes[15:0]), 80'(16'h1260));
    wait_req("req_after_accept", 1'b1, 4);

    // Redirect to 0x13 with the 0x10 read still outstanding
    lsz = req_log.size();
    pc_load = 1'b1; pc_new = 64'h13;
    #1;
    check("redir_valid_low", 80'(instr_valid), 80'(0));
    @(negedge clk);
    pc_load = 1'b0; fixed_lat = -1;
    #1;
    for (int n = 0; n < 40 && req_log.size() <= lsz; n++) begin @(negedge clk); #1; end
    check("redir_refetch", 80'(req_log.size() > lsz ? req_log[lsz] : -1), 80'(32'h10));
    wait_valid("nop_valid", 40);
    check("nop_pc", 80'(instr_pc), 80'(64'h13));
    check("nop_head", 80'({instr_bytes[7:0], instr_len, instr_valp[7:0]}), 80'({8'h10, 4'd1, 8'h14}));
    accept();
    check("halt_head", 80'({instr_valid, instr_pc[7:0], instr_bytes[7:0], instr_len}), 80'({1'b1, 8'h14, 8'h00, 4'd1}));
    accept();
    wait_req("halt_pending_done", 1'b0, 30);
    idle_no_req("halted_no_req", 20);
    check("halted_presented", 80'({instr_valid, instr_pc[7:0]}), 80'({1'b1, 8'h15}));

    // Invalid icode
    redirect(64'h40);
    wait_valid("err_valid", 40);
    check("err_flags", 80'({instr_len, need_regids, need_valc, instr_err}), 80'({4'd1, 1'b0, 1'b0, 1'b1}));
    check("err_valp", 80'(instr_valp), 80'(64'h41));
    accept();
    wait_req("err_pending_done", 1'b0, 30);
    idle_no_req("err_halted_no_req", 20);
    check("err_presented", 80'({instr_valid, instr_pc[7:0]}), 80'({1'b1, 8'h41}));

    // Length-decode table
    for (int i = 0; i < 16; i++) begin
      img[512 + 16*i] = vecs[i].byte0;
      redirect(64'(512 + 16*i));
      wait_valid($sformatf("tbl%0d_valid", i), 40);
      check($sformatf("tbl%0d_flags", i), 80'({instr_len, need_regids, need_valc, instr_err}),
            80'({vecs[i].len, vecs[i].rg, vecs[i].vc, vecs[i].err}));
      check($sformatf("tbl%0d_valp", i), 80'(instr_valp), 80'(512 + 16*i + int'(vecs[i].len)));
    end

    // Reset while a request is outstanding; a late ack must be ignored
    fixed_lat = 20;
    redirect(64'h80);
    wait_req("rst_req_out", 1'b1, 10);
    auto_mem = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 80'({mem_req, instr_valid}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = {8{8'hEE}};
    lsz = req_log.size();
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    auto_mem = 1'b1; fixed_lat = -1;
    for (int n = 0; n < 10 && req_log.size() <= lsz; n++) begin @(negedge clk); #1; end
    check("rst_first_req", 80'(req_log.size() > lsz ? req_log[lsz] : -1), 80'(0));
    wait_valid("rst_valid", 60);
    check("rst_head", 80'({instr_pc[7:0], instr_bytes[15:0]}), 80'({8'h00, 16'hF430}));

    // Randomized program checked against the instruction-level model
    p = 256;
    while (p < 768) begin
      ic  = int'($urandom_range(1, 11));
      icn = 4'(ic);
      rg  = 1'b0; vc = 1'b0;
      case (ic)
        1, 9:         ln = 1;
        2, 6, 10, 11: begin ln = 2;  rg = 1'b1; end
        3, 4, 5:      begin ln = 10; rg = 1'b1; vc = 1'b1; end
        default:      begin ln = 9;  vc = 1'b1; end
      endcase
      img[p] = {icn, 4'($urandom_range(0, 15))};
      for (int k = 1; k < ln; k++) img[p + k] = 8'($urandom_range(0, 255));
      rec_len[p] = ln; rec_rg[p] = rg; rec_vc[p] = vc;
      if (p < 384) starts.push_back(p);
      p += ln;
    end
    for (int a = p; a < 1024; a++) begin
      img[a] = 8'h10;
      rec_len[a] = 1; rec_rg[a] = 1'b0; rec_vc[a] = 1'b0;
    end

    redirect(64'h100);
    exp_pc = 64'h100;
    accepted = 0; idle = 0; cyc = 0;
    while (accepted < 50 && cyc < 6000 && idle < 100) begin
      @(negedge clk);
      cyc++;
      instr_ready = ($urandom_range(0, 2) != 0);
      pc_load     = ($urandom_range(0, 29) == 0);
      if (pc_load) pc_new = 64'(starts[$urandom_range(0, starts.size() - 1)]);
      #1;
      if (pc_load) begin
        check("rand_redirect_valid", 80'(instr_valid), 80'(0));
        exp_pc = pc_new;
        idle = 0;
      end else if (instr_valid) begin
        idle = 0;
        key = int'(exp_pc[31:0]);
        check("rand_in_program", 80'(rec_len.exists(key)), 80'(1));
        if (!rec_len.exists(key)) break;
        check("rand_pc", 80'(instr_pc), 80'(exp_pc));
        check("rand_flags", 80'({instr_len, need_regids, need_valc, instr_err}),
              80'({4'(rec_len[key]), rec_rg[key], rec_vc[key], 1'b0}));
        check("rand_valp", 80'(instr_valp), 80'(exp_pc + 64'(rec_len[key])));
        exp_b = '0; mask = '0;
        for (int k = 0; k < rec_len[key]; k++) begin
          exp_b[8*k +: 8] = img[(key + k) & 1023];
          mask[8*k +: 8]  = 8'hFF;
        end
        check("rand_bytes", instr_bytes & mask, exp_b);
        if (instr_ready) begin
          accepted++;
          exp_pc = exp_pc + 64'(rec_len[key]);
        end
      end else begin
        idle++;
      end
    end
    check("rand_progress", 80'(accepted), 80'(50));
    @(negedge clk);
    instr_ready = 1'b0; pc_load = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
